// File: rtl/core_pkg.sv
// Shared core-wide word definitions used across the execute stage.
package core_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/decoder_pkg.sv
// Decoder-visible encodings: divider opcodes and divider FSM states.
package decoder_pkg;
  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, compare, conditional subtract; combinational.
// No backpressure; the caller decides when to register the result.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the compare exact when the divisor magnitude uses the full word.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU iterative divider; done 1 cycle after accept for /0 and overflow, WIDTH+2 otherwise.
// start is only accepted in IDLE or DONE; while busy the core must stall and start is ignored.
module div_unit
  import decoder_pkg::*;
#(
  parameter int WIDTH = core_pkg::XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  div_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  div_op_t          op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;
  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] fix_res;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    accept    = start && ((state == DIV_ST_IDLE) || (state == DIV_ST_DONE));
    is_signed = (op == DIV_DIV) || (op == DIV_REM);
    neg_a     = is_signed && a[WIDTH-1];
    neg_b     = is_signed && b[WIDTH-1];
    mag_a     = neg_a ? (~a + 1'b1) : a;
    mag_b     = neg_b ? (~b + 1'b1) : b;
    div_zero  = (b == '0);
    overflow  = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    // Overflow quotient is the dividend itself (the most negative word); remainder is zero.
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
    // sign_a/sign_b are only ever set for signed ops, so unsigned ops pass through.
    if (op_q[1]) fix_res = sign_a ? (~rem_q + 1'b1) : rem_q;
    else         fix_res = (sign_a ^ sign_b) ? (~quo_q + 1'b1) : quo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DIV_ST_IDLE;
      op_q   <= DIV_DIV;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt    <= '0;
      res    <= '0;
    end else begin
      case (state)
        DIV_ST_RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= DIV_ST_FIX;
        end
        DIV_ST_FIX: begin
          res   <= fix_res;
          state <= DIV_ST_DONE;
        end
        default: begin
          if (accept) begin
            op_q   <= op;
            sign_a <= neg_a;
            sign_b <= neg_b;
            rem_q  <= '0;
            quo_q  <= mag_a;
            dvs_q  <= mag_b;
            cnt    <= CW'(WIDTH - 1);
            if (div_zero || overflow) begin
              res   <= special_res;
              state <= DIV_ST_DONE;
            end else begin
              state <= DIV_ST_RUN;
            end
          end else begin
            state <= DIV_ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == DIV_ST_RUN) || (state == DIV_ST_FIX);
  assign done = (state == DIV_ST_DONE);
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expectations queued at accept, checked on each done pulse.
module tb_div_unit;
  import decoder_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  div_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int   n_chk;
  int   n_bad;
  int   cyc;
  exp_t exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input div_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic sgn;
    sgn = (o == DIV_DIV) || (o == DIV_REM);
    if (y == 32'd0) return (o == DIV_REM || o == DIV_REMU) ? x : 32'hFFFF_FFFF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return (o == DIV_DIV) ? 32'h8000_0000 : 32'd0;
    case (o)
      DIV_DIV:  return 32'($signed(x) / $signed(y));
      DIV_REM:  return 32'($signed(x) % $signed(y));
      DIV_DIVU: return x / y;
      default:  return x % y;
    endcase
  endfunction

  function automatic int ref_lat(input div_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic sgn;
    sgn = (o == DIV_DIV) || (o == DIV_REM);
    if (y == 32'd0) return 1;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge with the DUT able to accept; start is held across one rising edge.
  task automatic issue(input div_op_t o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.res = ref_div(o, x, y);
    e.lat = ref_lat(o, x, y);
    e.acc = cyc;
    exp_q.push_back(e);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res", res, e.res);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = DIV_DIV;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_res", res, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(DIV_DIVU, 32'd100, 32'd7);          wait_idle(60);
    issue(DIV_REMU, 32'd100, 32'd7);          wait_idle(60);
    issue(DIV_DIV, 32'hFFFF_FFF9, 32'd2);     wait_idle(60);
    issue(DIV_REM, 32'hFFFF_FFF9, 32'd2);     wait_idle(60);
    issue(DIV_DIV, 32'd5, 32'd0);             wait_idle(10);
    issue(DIV_REM, 32'd5, 32'd0);             wait_idle(10);
    issue(DIV_DIVU, 32'd5, 32'd0);            wait_idle(10);
    issue(DIV_REMU, 32'hDEAD_BEEF, 32'd0);    wait_idle(10);
    issue(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(10);
    issue(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(10);
    issue(DIV_DIVU, 32'hFFFF_FFFF, 32'd1);    wait_idle(60);
    issue(DIV_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF); wait_idle(60);
    issue(DIV_DIV, 32'd7, 32'hFFFF_FFFE);     wait_idle(60);
    issue(DIV_REM, 32'h8000_0000, 32'd3);     wait_idle(60);

    // Start pulsed mid-division must be ignored.
    issue(DIV_DIVU, 32'd1000, 32'd10);
    repeat (8) @(negedge clk);
    chk("busy_mid_run", 32'(busy), 32'd1);
    op = DIV_REMU; a = 32'd77; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);

    // Back-to-back: second start lands in the DONE cycle.
    issue(DIV_DIVU, 32'd50, 32'd6);
    begin
      int n;
      n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_first_done", 32'(done), 32'd1);
    end
    issue(DIV_REM, 32'hFFFF_FF9C, 32'd7);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle(60);

    // Reset partway through aborts with no done pulse.
    issue(DIV_DIVU, 32'd12345, 32'd17);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", res, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(DIV_DIVU, 32'd9, 32'd3);            wait_idle(60);

    for (int i = 0; i < 12; i++) begin
      div_op_t     ro;
      logic [31:0] rx;
      logic [31:0] ry;
      ro = div_op_t'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i % 3 == 1) ry = ry >> $urandom_range(0, 31);
      issue(ro, rx, ry);
      wait_idle(60);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
